// File: rtl/rc4_key_dispatcher.sv
// rc4_key_dispatcher: round-robin key dispatcher for a pool of RC4 decrypt cores,
// stopping the search on the first successful key.
module rc4_key_dispatcher #(
    parameter int NUM_CORES = 4,
    parameter int KEY_W     = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [KEY_W-1:0]           lower_key_index,
    input  logic [KEY_W-1:0]           upper_key_index,
    output logic [NUM_CORES-1:0]       core_start,
    output logic [NUM_CORES*KEY_W-1:0] core_key,
    input  logic [NUM_CORES-1:0]       core_finish,
    input  logic [NUM_CORES-1:0]       core_found,
    output logic                       stop_search,
    output logic                       busy,
    output logic                       done,
    output logic                       key_found,
    output logic [KEY_W-1:0]           successful_key
);
    localparam int PW = $clog2(NUM_CORES);

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t               state;
    logic [KEY_W:0]       next_key;
    logic [KEY_W-1:0]     upper_q;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        sel;
    logic [PW-1:0]        win;
    logic                 sel_v;
    logic [NUM_CORES-1:0] outstanding;
    logic [NUM_CORES-1:0] hit;
    int                   k;

    assign hit = core_finish & core_found & outstanding;

    // Eligibility uses the registered outstanding bits, so a core finishing
    // this cycle is only re-dispatched on the next one.
    always_comb begin
        sel   = '0;
        sel_v = 1'b0;
        win   = '0;
        k     = 0;
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            k = (int'(ptr) + j) % NUM_CORES;
            if (!outstanding[PW'(k)]) begin
                sel   = PW'(k);
                sel_v = 1'b1;
            end
        end
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (hit[i]) win = PW'(i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            next_key       <= '0;
            upper_q        <= '0;
            ptr            <= '0;
            outstanding    <= '0;
            core_start     <= '0;
            core_key       <= '0;
            stop_search    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            key_found      <= 1'b0;
            successful_key <= '0;
        end else begin
            core_start  <= '0;
            outstanding <= outstanding & ~core_finish;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        upper_q     <= upper_key_index;
                        next_key    <= {1'b0, lower_key_index};
                        ptr         <= '0;
                        outstanding <= '0;
                        key_found   <= 1'b0;
                        stop_search <= 1'b0;
                        if (lower_key_index > upper_key_index) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= DISPATCH;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
                DISPATCH: begin
                    if (|hit) begin
                        successful_key <= core_key[win*KEY_W +: KEY_W];
                        key_found      <= 1'b1;
                        stop_search    <= 1'b1;
                        state          <= DRAIN;
                    end else if (sel_v) begin
                        core_start[sel]               <= 1'b1;
                        core_key[sel*KEY_W +: KEY_W]  <= next_key[KEY_W-1:0];
                        outstanding                   <= (outstanding & ~core_finish) | (NUM_CORES'(1) << sel);
                        next_key                      <= next_key + 1'b1;
                        ptr                           <= (sel == PW'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
                        if (next_key == {1'b0, upper_q}) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (|hit && !key_found) begin
                        successful_key <= core_key[win*KEY_W +: KEY_W];
                        key_found      <= 1'b1;
                        stop_search    <= 1'b1;
                    end
                    if (outstanding == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
